// File: rtl/l2_lru_sequencer_pkg.sv
// Shared types and constants for the L2 LRU/lock array front-end sequencer.
package l2_lru_sequencer_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } l2_lru_seq_state_t;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  // Bit positions in the arbiter's one-hot grant vector
  localparam int unsigned GNT_FILL = 0;
  localparam int unsigned GNT_ACC  = 1;

  // Index width that never collapses to zero bits for single-entry spaces
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_lru_seq_arbiter.sv
// Fill-over-access priority arbiter with a saturating starvation counter that
// forces a pending access through after STARVE_LIMIT consecutive losses.
module l2_lru_seq_arbiter
  import l2_lru_sequencer_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       fill_valid,
  input  logic       acc_valid,
  output logic [1:0] grant_c,
  output logic       starve_override_c
);

  localparam int unsigned CNT_W = idx_width(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starve_hit;
  logic             force_acc;

  assign starve_hit = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign force_acc  = en & acc_valid & starve_hit;

  // Priority select and counter update
  always_comb begin
    grant_c           = '0;
    starve_override_c = 1'b0;
    starve_cnt_d      = starve_cnt_q;

    grant_c[GNT_FILL] = en & fill_valid & ~force_acc;
    grant_c[GNT_ACC]  = en & acc_valid & (~fill_valid | force_acc);
    starve_override_c = force_acc & fill_valid;

    if (!en || !acc_valid || grant_c[GNT_ACC]) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/l2_lru_sequencer.sv
// Read-port sequencer for the L2 LRU/lock array: lock-clearing sweeps, fill/access
// arbitration and the two-phase read/update protocol. Optional: L2_LRU_SEQ_STATS_EN.
module l2_lru_sequencer
  import l2_lru_sequencer_pkg::*;
#(
  parameter int unsigned NUM_SETS        = 256,
  parameter int unsigned NUM_WAYS        = 8,
  parameter int unsigned STARVE_LIMIT    = STARVE_LIMIT_DEFAULT,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned SET_INDEX_WIDTH = idx_width(NUM_SETS),
  parameter int unsigned WAY_INDEX_WIDTH = idx_width(NUM_WAYS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_req_valid,
  output logic                       fill_req_ready,
  input  logic [SET_INDEX_WIDTH-1:0] fill_req_set,
  input  logic                       fill_req_lock,
  input  logic [ID_WIDTH-1:0]        fill_req_id,
  output logic                       fill_resp_valid,
  output logic [WAY_INDEX_WIDTH-1:0] fill_resp_way,
  output logic [ID_WIDTH-1:0]        fill_resp_id,
  input  logic                       acc_req_valid,
  output logic                       acc_req_ready,
  input  logic [SET_INDEX_WIDTH-1:0] acc_req_set,
  input  logic                       acc_hit,
  input  logic [WAY_INDEX_WIDTH-1:0] acc_hit_way,
  input  logic                       unlock_all_req,
  output logic                       sweep_busy,
  output logic                       lru_fill_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
  input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,
  output logic                       lru_lock_en,
  output logic                       lru_lock_value,
  output logic                       lru_access_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
  output logic                       lru_access_update_en,
  output logic [WAY_INDEX_WIDTH-1:0] lru_access_update_way
`ifdef L2_LRU_SEQ_STATS_EN
  ,
  output logic [31:0]                stat_fills,
  output logic [31:0]                stat_accesses,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_starve_overrides
`endif
);

  l2_lru_seq_state_t          state_q, state_d;
  logic [SET_INDEX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic                       unlock_pend_q, unlock_pend_d;
  logic                       acc_upd_pend_q;
  logic                       arb_en;
  logic [1:0]                 grant_c;
  logic                       fill_grant_c;
  logic                       acc_grant_c;
  logic                       starve_override_c;
  logic                       unlock_take_c;
  logic                       sweep_start_c;

  // A deferred unlock blocks new grants so the sweep cannot be starved
  assign arb_en       = (state_q == RUN) & ~unlock_pend_q;
  assign fill_grant_c = grant_c[GNT_FILL];
  assign acc_grant_c  = grant_c[GNT_ACC];
  assign unlock_take_c = (state_q == RUN) & (unlock_all_req | unlock_pend_q)
                         & ~fill_grant_c & ~acc_grant_c;

  l2_lru_seq_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arbiter (
    .clk              (clk),
    .reset            (reset),
    .en               (arb_en),
    .fill_valid       (fill_req_valid),
    .acc_valid        (acc_req_valid),
    .grant_c          (grant_c),
    .starve_override_c(starve_override_c)
  );

  // Next-state and array-port drive
  always_comb begin
    state_d        = state_q;
    sweep_idx_d    = sweep_idx_q;
    unlock_pend_d  = unlock_pend_q;
    sweep_start_c  = 1'b0;
    fill_req_ready = 1'b0;
    acc_req_ready  = 1'b0;
    lru_fill_en    = 1'b0;
    lru_fill_set   = '0;
    lru_lock_en    = 1'b0;
    lru_lock_value = 1'b0;
    lru_access_en  = 1'b0;
    lru_access_set = '0;

    case (state_q)
      INIT, SWEEP: begin
        // Unlocked fill writes the set's lock bits to zero; quiet while reset is held
        lru_fill_en  = reset;
        lru_fill_set = sweep_idx_q;
        if (sweep_idx_q == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
          sweep_idx_d = '0;
          state_d     = RUN;
        end else begin
          sweep_idx_d = sweep_idx_q + SET_INDEX_WIDTH'(1);
        end
      end
      RUN: begin
        fill_req_ready = fill_grant_c;
        acc_req_ready  = acc_grant_c;
        if (fill_grant_c) begin
          lru_fill_en    = 1'b1;
          lru_fill_set   = fill_req_set;
          lru_lock_en    = 1'b1;
          lru_lock_value = fill_req_lock;
        end
        if (acc_grant_c) begin
          lru_access_en  = 1'b1;
          lru_access_set = acc_req_set;
        end
        if (unlock_take_c) begin
          state_d       = SWEEP;
          sweep_idx_d   = '0;
          unlock_pend_d = 1'b0;
          sweep_start_c = 1'b1;
        end else if (unlock_all_req) begin
          unlock_pend_d = 1'b1;
        end
      end
      default: begin
        state_d     = INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      sweep_idx_q   <= '0;
      unlock_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      unlock_pend_q <= unlock_pend_d;
    end
  end

  // Second-phase bookkeeping: fill response and access update pending flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_resp_valid <= 1'b0;
      fill_resp_id    <= '0;
      acc_upd_pend_q  <= 1'b0;
      sweep_busy      <= 1'b1;
    end else begin
      fill_resp_valid <= fill_grant_c;
      if (fill_grant_c) begin
        fill_resp_id <= fill_req_id;
      end
      acc_upd_pend_q <= acc_grant_c;
      sweep_busy     <= (state_d != RUN);
    end
  end

  // Array returns the victim in the response cycle, so it passes straight through
  assign fill_resp_way         = fill_resp_valid ? lru_fill_way : '0;
  assign lru_access_update_en  = acc_upd_pend_q & acc_hit;
  assign lru_access_update_way = lru_access_update_en ? acc_hit_way : '0;

`ifdef L2_LRU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_fills            <= '0;
      stat_accesses         <= '0;
      stat_hits             <= '0;
      stat_starve_overrides <= '0;
    end else if (sweep_start_c) begin
      stat_fills            <= '0;
      stat_accesses         <= '0;
      stat_hits             <= '0;
      stat_starve_overrides <= '0;
    end else begin
      stat_fills            <= stat_fills + 32'(fill_grant_c);
      stat_accesses         <= stat_accesses + 32'(acc_grant_c);
      stat_hits             <= stat_hits + 32'(lru_access_update_en);
      stat_starve_overrides <= stat_starve_overrides + 32'(starve_override_c);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = starve_override_c ^ sweep_start_c;
`endif

endmodule

// File: tb/tb_l2_lru_sequencer.sv
// Directed bench for l2_lru_sequencer with NUM_SETS=4 and a one-cycle LRU read stub.
module tb_l2_lru_sequencer;

  localparam int unsigned NSETS = 4;
  localparam int unsigned SW    = 2;
  localparam int unsigned WW    = 3;
  localparam int unsigned IW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fill_req_valid, fill_req_ready, fill_req_lock;
  logic [SW-1:0] fill_req_set;
  logic [IW-1:0] fill_req_id;
  logic          fill_resp_valid;
  logic [WW-1:0] fill_resp_way;
  logic [IW-1:0] fill_resp_id;
  logic          acc_req_valid, acc_req_ready, acc_hit;
  logic [SW-1:0] acc_req_set;
  logic [WW-1:0] acc_hit_way;
  logic          unlock_all_req, sweep_busy;
  logic          lru_fill_en, lru_lock_en, lru_lock_value;
  logic [SW-1:0] lru_fill_set;
  logic [WW-1:0] lru_fill_way;
  logic          lru_access_en, lru_access_update_en;
  logic [SW-1:0] lru_access_set;
  logic [WW-1:0] lru_access_update_way;
  logic [WW-1:0] stub_way;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l2_lru_sequencer #(
    .NUM_SETS(NSETS), .NUM_WAYS(8), .STARVE_LIMIT(8), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
    .fill_req_set(fill_req_set), .fill_req_lock(fill_req_lock), .fill_req_id(fill_req_id),
    .fill_resp_valid(fill_resp_valid), .fill_resp_way(fill_resp_way), .fill_resp_id(fill_resp_id),
    .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready), .acc_req_set(acc_req_set),
    .acc_hit(acc_hit), .acc_hit_way(acc_hit_way),
    .unlock_all_req(unlock_all_req), .sweep_busy(sweep_busy),
    .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set), .lru_fill_way(lru_fill_way),
    .lru_lock_en(lru_lock_en), .lru_lock_value(lru_lock_value),
    .lru_access_en(lru_access_en), .lru_access_set(lru_access_set),
    .lru_access_update_en(lru_access_update_en), .lru_access_update_way(lru_access_update_way)
  );

  // LRU array stub: victim way readable the cycle after a fill read
  always_ff @(posedge clk) begin
    if (lru_fill_en) lru_fill_way <= stub_way;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sweep_cycle(input int k);
    @(negedge clk);
    check("sweep_fill_en", 32'(lru_fill_en), 1);
    check("sweep_set", 32'(lru_fill_set), 32'(k));
    check("sweep_lock_en", 32'(lru_lock_en), 0);
    check("sweep_busy", 32'(sweep_busy), 1);
    check("sweep_readies", 32'({fill_req_ready, acc_req_ready}), 0);
    check("sweep_no_resp", 32'(fill_resp_valid), 0);
    step();
  endtask

  initial begin
    reset = 1'b0;
    fill_req_valid = 0; fill_req_set = '0; fill_req_lock = 0; fill_req_id = '0;
    acc_req_valid = 0; acc_req_set = '0; acc_hit = 0; acc_hit_way = '0;
    unlock_all_req = 0; stub_way = '0; lru_fill_way = '0;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_busy", 32'(sweep_busy), 1);
    check("rst_fill_en", 32'(lru_fill_en), 0);
    check("rst_resp", 32'({fill_resp_valid, fill_resp_way, fill_resp_id}), 0);
    check("rst_upd", 32'(lru_access_update_en), 0);
    step();
    reset = 1'b1;

    // Init sweep over sets 0..3 with a fill pending that must not be granted
    fill_req_valid = 1; fill_req_set = 2'd1; acc_req_valid = 1;
    for (int k = 0; k < int'(NSETS); k++) check_sweep_cycle(k);

    // First RUN cycle: locked fill to set 3
    acc_req_valid = 0;
    fill_req_set = 2'd3; fill_req_lock = 1; fill_req_id = 4'd5; stub_way = 3'd2;
    @(negedge clk);
    check("run_busy_low", 32'(sweep_busy), 0);
    check("fill_ready", 32'(fill_req_ready), 1);
    check("fill_set", 32'(lru_fill_set), 3);
    check("fill_lock", 32'({lru_fill_en, lru_lock_en, lru_lock_value}), 32'b111);
    step();

    // Fill response; same cycle grants access to set 1
    fill_req_valid = 0; fill_req_lock = 0; acc_req_valid = 1; acc_req_set = 2'd1;
    @(negedge clk);
    check("resp_valid", 32'(fill_resp_valid), 1);
    check("resp_way", 32'(fill_resp_way), 2);
    check("resp_id", 32'(fill_resp_id), 5);
    check("acc_ready", 32'(acc_req_ready), 1);
    check("acc_set", 32'({lru_access_en, lru_access_set}), 32'b101);
    check("acc_no_fill", 32'(lru_fill_en), 0);
    step();

    // Hit way 6 one cycle after grant
    acc_req_valid = 0; acc_hit = 1; acc_hit_way = 3'd6;
    @(negedge clk);
    check("upd_en", 32'(lru_access_update_en), 1);
    check("upd_way", 32'(lru_access_update_way), 6);
    check("resp_single", 32'(fill_resp_valid), 0);
    step();

    // Stray hit after no grant is ignored; grant access to set 2
    acc_req_valid = 1; acc_req_set = 2'd2;
    @(negedge clk);
    check("stray_hit", 32'(lru_access_update_en), 0);
    check("acc2_ready", 32'(acc_req_ready), 1);
    step();

    // Miss after grant: no update
    acc_req_valid = 0; acc_hit = 0;
    @(negedge clk);
    check("miss_no_upd", 32'(lru_access_update_en), 0);
    step();

    // Continuous fills versus a held access: access forced on the 9th cycle
    fill_req_valid = 1; fill_req_set = 2'd0; acc_req_valid = 1; acc_req_set = 2'd3;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      check("excl", 32'(lru_fill_en & lru_access_en), 0);
      if (n == 9) begin
        check("starve_acc", 32'(acc_req_ready), 1);
        check("starve_fill", 32'(fill_req_ready), 0);
      end else begin
        check("starve_fill_wins", 32'({fill_req_ready, acc_req_ready}), 32'b10);
      end
      step();
    end

    // Unlock during a fill grant is deferred one cycle
    acc_req_valid = 0; unlock_all_req = 1;
    @(negedge clk);
    check("unl_defer_fill", 32'(fill_req_ready), 1);
    step();
    unlock_all_req = 0;
    @(negedge clk);
    check("unl_take_noready", 32'(fill_req_ready), 0);
    check("unl_take_nofill", 32'(lru_fill_en), 0);
    step();
    unlock_all_req = 1; acc_req_valid = 1;
    check_sweep_cycle(0);
    unlock_all_req = 0;
    for (int k = 1; k < int'(NSETS); k++) check_sweep_cycle(k);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("no_resweep", 32'(sweep_busy), 0);
      check("post_sweep_fill", 32'(fill_req_ready), 1);
      step();
    end

    // Reset during a sweep at set 2 restarts from set 0
    fill_req_valid = 0; acc_req_valid = 0; unlock_all_req = 1;
    step();
    unlock_all_req = 0;
    check_sweep_cycle(0);
    check_sweep_cycle(1);
    @(negedge clk);
    check("mid_set2", 32'(lru_fill_set), 2);
    reset = 1'b0;
    #1;
    check("mid_rst_fill_en", 32'(lru_fill_en), 0);
    check("mid_rst_busy", 32'(sweep_busy), 1);
    step();
    reset = 1'b1;
    for (int k = 0; k < int'(NSETS); k++) check_sweep_cycle(k);

    // Reset right after a fill grant drops its response
    fill_req_valid = 1; fill_req_id = 4'd9;
    @(negedge clk);
    check("pre_rst_grant", 32'(fill_req_ready), 1);
    reset = 1'b0;
    fill_req_valid = 0;
    step();
    @(negedge clk);
    check("rst_drop_resp", 32'(fill_resp_valid), 0);
    check("rst_drop_id", 32'(fill_resp_id), 0);
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_lru_sequencer.md
Name: l2_lru_sequencer

Overview:
Front-end controller for the L2 LRU/lock array. It shares the array's single read port between three requesters: the fill path, the tag-lookup access path, and a software unlock-all command. It enforces the two-phase protocol, where the read is issued one cycle and the update follows the next. After reset and on command, it sweeps every set to clear lock bits. Fill requesters receive the chosen victim way one cycle after grant.

Parameters:
NUM_SETS, 256, sets in the LRU array (power of 2)
NUM_WAYS, 8, ways per set (1, 2, 4 or 8)
STARVE_LIMIT, 8, consecutive cycles an access may lose to fills before it is forced through
ID_WIDTH, 4, opaque fill tag returned with the response
SET_INDEX_WIDTH, $clog2(NUM_SETS), derived
WAY_INDEX_WIDTH, $clog2(NUM_WAYS), derived

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low; 0 = reset asserted
fill_req_valid  in  1  fill request
fill_req_ready  out  1  fill accepted this cycle
fill_req_set  in  SET_INDEX_WIDTH  set to fill
fill_req_lock  in  1  lock the filled way
fill_req_id  in  ID_WIDTH  requester tag
fill_resp_valid  out  1  victim way valid
fill_resp_way  out  WAY_INDEX_WIDTH  victim way (sampled from lru_fill_way)
fill_resp_id  out  ID_WIDTH  tag of the granted fill
acc_req_valid  in  1  access lookup
acc_req_ready  out  1  access granted this cycle
acc_req_set  in  SET_INDEX_WIDTH  set looked up
acc_hit  in  1  cycle after grant: hit occurred
acc_hit_way  in  WAY_INDEX_WIDTH  cycle after grant: hit way
unlock_all_req  in  1  pulse: clear all lock bits
sweep_busy  out  1  init/unlock sweep in progress
lru_fill_en  out  1  to LRU
lru_fill_set  out  SET_INDEX_WIDTH  to LRU
lru_fill_way  in  WAY_INDEX_WIDTH  from LRU, valid the cycle after lru_fill_en
lru_lock_en  out  1  to LRU
lru_lock_value  out  1  to LRU
lru_access_en  out  1  to LRU
lru_access_set  out  SET_INDEX_WIDTH  to LRU
lru_access_update_en  out  1  to LRU
lru_access_update_way  out  WAY_INDEX_WIDTH  to LRU

Behaviour:
- FSM states: INIT, RUN, SWEEP. Reset enters INIT with sweep_idx=0.
- Reset values: all ready/valid/enable outputs 0; sweep_busy 1; fill_resp_way/id 0; starve counter 0.
- INIT/SWEEP:
  - Each cycle drive lru_fill_en=1, lru_fill_set=sweep_idx, lru_lock_en=0. Lock bits are written to 0 when a fill has no lock.
  - sweep_idx increments each cycle. After set NUM_SETS-1, go to RUN; sweep_busy drops the following cycle.
  - Both readies are 0. No fill_resp is generated for sweep fills.
- RUN arbitration, one grant per cycle:
  - Default priority is fill > access.
  - If starve_cnt==STARVE_LIMIT and acc_req_valid, access wins and starve_cnt clears.
  - starve_cnt increments when an access is pending but not granted (saturating). It clears when an access is granted or no access is pending.
- Fill grant:
  - Drive lru_fill_en=1, lru_fill_set=fill_req_set, lru_lock_en=1, lru_lock_value=fill_req_lock.
  - Every normal fill asserts lock_en so other ways' lock bits are preserved.
  - Next cycle: fill_resp_valid=1, fill_resp_way=lru_fill_way, fill_resp_id=registered id. Responses are single-cycle with no backpressure.
- Access grant:
  - Drive lru_access_en=1, lru_access_set=acc_req_set.
  - Next cycle: lru_access_update_en = acc_hit, lru_access_update_way = acc_hit_way.
  - acc_hit is ignored in any cycle not following an access grant.
- Never assert lru_fill_en and lru_access_en in the same cycle.
- An update cycle may overlap the next grant; the array forwards new data, so there is no bubble.
- unlock_all_req:
  - Latched if it arrives while busy.
  - Taken in RUN only when no grant is outstanding in the current cycle (grant pending → defer one cycle).
  - Enters SWEEP from sweep_idx=0.
  - A request arriving during SWEEP is merged into the current sweep, not repeated.
- Reset mid-sweep restarts INIT from set 0.
- Reset mid-operation drops any pending fill_resp and update.

Optional Feature:
L2_LRU_SEQ_STATS_EN
- Defined: adds 32-bit wrapping counters for fill grants, access grants, access hits, and starvation overrides. They are exposed on outputs stat_fills, stat_accesses, stat_hits and stat_starve_overrides, and cleared by reset and by each sweep start.
- Undefined: no counters and no stat ports.

Decomposition:
- Shared defines package: l2_lru_seq_state_t enum (INIT, RUN, SWEEP) and the default STARVE_LIMIT constant.
- One natural sub-module: l2_lru_seq_arbiter, which is combinational priority plus the starve counter and emits the grant one-hot.
- FSM, sweep counter and response registers stay in the top module.

Test Plan:
- Release reset, NUM_SETS=4 → lru_fill_en high for 4 cycles on sets 0..3 with lock_en=0; sweep_busy falls in cycle 5; readies rise.
- Fill set 3, lock=1, id=5; stub returns way 2 → next cycle fill_resp_valid=1, way=2, id=5; lock_en=1 and lock_value=1 on the grant cycle.
- Grant access to set 1, then acc_hit=1 with way=6 → lru_access_update_en=1, way=6 exactly one cycle after grant; with acc_hit=0 there is no update.
- Continuous fills plus a held access, STARVE_LIMIT=8 → access granted on the 9th cycle; fill_req_ready=0 that cycle.
- Pulse unlock_all_req twice during RUN traffic → exactly one sweep of NUM_SETS cycles; both readies 0 throughout.
- Drop reset mid-sweep at set 2 → INIT restarts at set 0; no fill_resp emitted.
